data_mem_responder: RTL and testbench

Multi-cycle data-memory responder answering load/store requests from the pipeline memory stage over a valid/ready request channel and a valid/ready response channel.
Replaces the single-cycle data memory with a configurable-latency model. The memory stage can then be verified against wait states.
Holds the word array internally and serves one transaction at a time.

---
 rtl/data_mem_responder_pkg.sv | 25 ++
 rtl/data_mem_responder_if.sv | 27 ++
 rtl/data_mem_responder_dmem_array.sv | 33 +++
 rtl/data_mem_responder.sv | 115 +++++++++++
 tb/tb_data_mem_responder.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder and the memory stage that drives it.
package data_mem_responder_pkg;

  localparam int DMEM_ADDR_W = 10;
  localparam int DMEM_DATA_W = 32;

  // Widths used when packing EX/MEM fields onto the req_* channel
  localparam int REQ_ADDR_W  = DMEM_ADDR_W;
  localparam int REQ_WDATA_W = DMEM_DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

  function automatic int idx_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response channel between the memory stage (master) and the responder (slave).
interface data_mem_responder_if
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_W = REQ_ADDR_W,
  parameter int DATA_W = REQ_WDATA_W
);
  logic              req_valid;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_responder_dmem_array.sv
// Word array with synchronous write and registered read; the read register only
// updates on an enabled read so the value stays put while a response is pending.
module dmem_array
  import data_mem_responder_pkg::*;
#(
  parameter int DATA_W = DMEM_DATA_W,
  parameter int DEPTH  = 1024,
  parameter int IDX_W  = idx_width(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (en && !we) rdata_d = mem[addr];
  end

  always_ff @(posedge clk) begin
    if (en && we) mem[addr] <= wdata;
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle load/store responder: one transaction at a time, WAIT_CYCLES extra
// cycles between acceptance and the response, out-of-range accesses flagged.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_W      = DMEM_ADDR_W,
  parameter int DATA_W      = DMEM_DATA_W,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  data_mem_responder_if.slave  bus,
  output logic                 busy
);

  localparam int              CNT_W    = cnt_width(WAIT_CYCLES);
  localparam int              IDX_W    = idx_width(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
  localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W + 1)'(DEPTH);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                write_q, write_d;
  logic                commit, in_range, arr_en, arr_we;
  logic [DATA_W-1:0]   arr_rdata;

  assign in_range = ({1'b0, addr_q} < DEPTH_L);
  // A reset landing on the commit edge must leave the array untouched
  assign arr_en   = commit & in_range & rst_n;
  assign arr_we   = arr_en & write_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    write_q <= write_d;
  end

  // WAIT always spans WAIT_CYCLES counting edges plus the commit edge, giving
  // a response WAIT_CYCLES+1 edges after acceptance (one edge when WAIT_CYCLES=0).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    commit  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          write_d = bus.req_write;
          cnt_d   = CNT_LOAD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          commit  = 1'b1;
          err_d   = ~in_range;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (bus.resp_ready) begin
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = (state_q == ST_IDLE);
    bus.resp_valid = (state_q == ST_RESP);
    bus.resp_err   = err_q;
    busy           = (state_q != ST_IDLE);
    bus.resp_rdata = '0;
    if ((state_q == ST_RESP) && !write_q && !err_q) bus.resp_rdata = arr_rdata;
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_dmem_array (
    .clk   (clk),
    .en    (arr_en),
    .we    (arr_we),
    .addr  (addr_q[IDX_W-1:0]),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (2 wait cycles, 0 wait cycles,
// 512-word depth) checked against an array model of memory contents and latency.
module tb_data_mem_responder;

  localparam int NDUT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid   [NDUT];
  logic        req_write;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_ready;
  logic        req_ready_o [NDUT];
  logic        resp_valid_o[NDUT];
  logic        resp_err_o  [NDUT];
  logic        busy_o      [NDUT];
  logic [31:0] resp_rdata_o[NDUT];

  int lat_of   [NDUT] = '{3, 1, 3};
  int depth_of [NDUT] = '{1024, 1024, 512};

  logic [31:0] mdl    [NDUT][1024];
  bit          mdl_ok [NDUT][1024];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int WC = (g == 1) ? 0 : 2;
    localparam int DP = (g == 2) ? 512 : 1024;
    data_mem_responder_if #(.ADDR_W(10), .DATA_W(32)) bus ();
    assign bus.req_valid    = req_valid[g];
    assign bus.req_write    = req_write;
    assign bus.req_addr     = req_addr;
    assign bus.req_wdata    = req_wdata;
    assign bus.resp_ready   = resp_ready;
    assign req_ready_o[g]   = bus.req_ready;
    assign resp_valid_o[g]  = bus.resp_valid;
    assign resp_err_o[g]    = bus.resp_err;
    assign resp_rdata_o[g]  = bus.resp_rdata;
    data_mem_responder #(
      .ADDR_W(10), .DATA_W(32), .DEPTH(DP), .WAIT_CYCLES(WC)
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .busy  (busy_o[g])
    );
  end

  // Present a request while DUT s is idle; returns just after the accepting edge.
  task automatic accept(input int s, input bit wr, input logic [9:0] a, input logic [31:0] d);
    req_valid[s] = 1'b1;
    req_write    = wr;
    req_addr     = a;
    req_wdata    = d;
    n_vec++;
    if (req_ready_o[s] !== 1'b1) begin
      n_err++;
      $display("FAIL accept_ready dut%0d: req_ready=%b expected 1", s, req_ready_o[s]);
    end
    @(posedge clk); #1;
    n_vec++;
    if (busy_o[s] !== 1'b1) begin
      n_err++;
      $display("FAIL accept_busy dut%0d: busy=%b expected 1", s, busy_o[s]);
    end
  endtask

  // Wait for the response, check latency/data/error, then apply the access to the model.
  task automatic await_resp(input int s, input bit wr, input logic [9:0] a, input logic [31:0] d,
                            output logic [31:0] exp_rd, output bit chk_rd);
    int lat = 0;
    bit err;
    while (resp_valid_o[s] !== 1'b1 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    n_vec++;
    if (lat != lat_of[s]) begin
      n_err++;
      $display("FAIL latency dut%0d addr %h: got %0d edges want %0d", s, a, lat, lat_of[s]);
    end
    err    = (int'(a) >= depth_of[s]);
    exp_rd = (err || wr) ? 32'h0 : mdl[s][a];
    chk_rd = err || wr || mdl_ok[s][a];
    n_vec++;
    if (resp_err_o[s] !== err) begin
      n_err++;
      $display("FAIL resp_err dut%0d addr %h: got %b want %b", s, a, resp_err_o[s], err);
    end
    if (chk_rd) begin
      n_vec++;
      if (resp_rdata_o[s] !== exp_rd) begin
        n_err++;
        $display("FAIL resp_rdata dut%0d addr %h: got %h want %h", s, a, resp_rdata_o[s], exp_rd);
      end
    end
    if (wr && !err) begin
      mdl[s][a]    = d;
      mdl_ok[s][a] = 1'b1;
    end
  endtask

  task automatic release_resp(input int s);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    n_vec++;
    if ({resp_valid_o[s], resp_err_o[s], busy_o[s], req_ready_o[s]} !== 4'b0001) begin
      n_err++;
      $display("FAIL release dut%0d: {valid,err,busy,ready}=%b want 0001", s,
               {resp_valid_o[s], resp_err_o[s], busy_o[s], req_ready_o[s]});
    end
  endtask

  // Full transaction; during 'hold' cycles in RESP a new request is kept pending.
  task automatic txn(input int s, input bit wr, input logic [9:0] a, input logic [31:0] d,
                     input int hold);
    logic [31:0] exp_rd;
    bit          chk_rd;
    accept(s, wr, a, d);
    req_valid[s] = 1'b0;
    await_resp(s, wr, a, d, exp_rd, chk_rd);
    for (int i = 0; i < hold; i++) begin
      req_valid[s] = 1'b1;
      @(posedge clk); #1;
      n_vec++;
      if ({resp_valid_o[s], req_ready_o[s]} !== 2'b10 || (chk_rd && resp_rdata_o[s] !== exp_rd)) begin
        n_err++;
        $display("FAIL hold dut%0d cycle %0d: valid=%b ready=%b rdata=%h want valid=1 ready=0 rdata=%h",
                 s, i, resp_valid_o[s], req_ready_o[s], resp_rdata_o[s], exp_rd);
      end
    end
    req_valid[s] = 1'b0;
    release_resp(s);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int s = 0; s < NDUT; s++) begin
      n_vec++;
      if ({req_ready_o[s], resp_valid_o[s], resp_err_o[s], busy_o[s]} !== 4'b1000 ||
          resp_rdata_o[s] !== 32'h0) begin
        n_err++;
        $display("FAIL %s dut%0d: {ready,valid,err,busy}=%b rdata=%h want 1000 / 0", tag, s,
                 {req_ready_o[s], resp_valid_o[s], resp_err_o[s], busy_o[s]}, resp_rdata_o[s]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    req_valid  = '{default: 1'b0};
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_store_load();
    txn(0, 1'b1, 10'h009, 32'h0000_0002, 0);
    txn(0, 1'b0, 10'h009, 32'h0, 0);
  endtask

  task automatic test_wait0();
    logic [31:0] d = $urandom;
    txn(1, 1'b1, 10'h0A5, d, 0);
    txn(1, 1'b0, 10'h0A5, 32'h0, 0);
    txn(1, 1'b0, 10'h3FF, 32'h0, 1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_rd;
    bit          chk_rd;
    accept(0, 1'b1, 10'h111, 32'h0101_0101);
    req_write = 1'b0;
    req_wdata = $urandom;
    await_resp(0, 1'b1, 10'h111, 32'h0101_0101, exp_rd, chk_rd);
    release_resp(0);
    @(posedge clk); #1;
    n_vec++;
    if (busy_o[0] !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_second_accept dut0: busy=%b want 1", busy_o[0]);
    end
    req_valid[0] = 1'b0;
    await_resp(0, 1'b0, 10'h111, 32'h0, exp_rd, chk_rd);
    release_resp(0);
  endtask

  task automatic test_hold();
    logic [31:0] d = $urandom;
    txn(0, 1'b1, 10'h2C4, d, 0);
    txn(0, 1'b0, 10'h2C4, 32'h0, 5);
    txn(0, 1'b1, 10'h2C5, $urandom, 5);
  endtask

  task automatic test_out_of_range();
    for (int a = 0; a < 512; a++) txn(2, 1'b1, 10'(a), $urandom, 0);
    txn(2, 1'b1, 10'h3FF, $urandom, 0);
    txn(2, 1'b1, 10'h200, $urandom, 0);
    txn(2, 1'b0, 10'h3FF, 32'h0, 0);
    for (int a = 0; a < 512; a++) txn(2, 1'b0, 10'(a), 32'h0, 0);
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp_rd;
    bit          chk_rd;
    int          k = $urandom_range(0, 2);
    logic [31:0] d = $urandom;
    txn(0, 1'b1, 10'h010, 32'h1234_5678, 0);
    accept(0, 1'b1, 10'h010, 32'hDEAD_BEEF);
    req_valid[0] = 1'b0;
    repeat (k) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("reset_in_wait");
    rst_n = 1'b1;
    @(posedge clk); #1;
    txn(0, 1'b0, 10'h010, 32'h0, 0);
    accept(0, 1'b1, 10'h020, d);
    req_valid[0] = 1'b0;
    await_resp(0, 1'b1, 10'h020, d, exp_rd, chk_rd);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("reset_in_resp");
    rst_n = 1'b1;
    @(posedge clk); #1;
    txn(0, 1'b0, 10'h020, 32'h0, 0);
  endtask

  task automatic test_random();
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 60; i++) begin
        logic [9:0] a = 10'(10'h040 + $urandom_range(0, 7));
        txn(s, 1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 2));
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_wait0();
    test_back_to_back();
    test_hold();
    test_out_of_range();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
